hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: MEM_WAIT cycles before mem_err sets; range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 fwd_en  in  1  runtime forwarding enable, same meaning as the forwarding unit's enable.
REQ-005 id_src1, id_src2  in  4 each  ID-stage source register numbers.
REQ-006 id_src1_vld, id_src2_vld  in  1 each  source actually read by the ID instruction.
REQ-007 ex_dest, mem_dest  in  4 each  EX- and MEM-stage destination registers.
REQ-008 ex_wb_en, mem_wb_en  in  1 each  EX/MEM instruction writes back.
REQ-009 ex_mem_rd  in  1  EX instruction is a load.
REQ-010 br_taken  in  1  branch resolved taken in EX.
REQ-011 mem_req, mem_ready  in  1 each  MEM-stage data access active / data memory completes this cycle.
REQ-012 hz_stall  out  1  hold PC and IF/ID.
REQ-013 hz_bubble  out  1  load NOP into ID/EX.
REQ-014 hz_flush  out  1  clear IF/ID and ID/EX; PC takes branch target.
REQ-015 pipe_freeze  out  1  hold every pipeline register.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 state_o  out  2  current FSM state, for debug.

Function
REQ-018 raw = per valid source, (ex_wb_en & src==ex_dest) | (mem_wb_en & src==mem_dest), ORed over both sources.
REQ-019 lu = per valid source, ex_wb_en & ex_mem_rd & src==ex_dest, ORed over both sources.
REQ-020 stall_req = fwd_en ? lu : raw; invalid sources never cause a stall.
REQ-021 wait_req = mem_req & !mem_ready.
REQ-022 Priority: wait_req > br_taken > stall_req.
REQ-023 wait_req: pipe_freeze=1 and hz_stall=1; hz_flush=0, hz_bubble=0.
REQ-024 Else br_taken: hz_flush=1 and hz_stall=0, hz_bubble=0; a coincident stall_req is discarded.
REQ-025 Else stall_req: hz_stall=1 and hz_bubble=1.
REQ-026 Else all of hz_stall, hz_bubble, hz_flush, pipe_freeze = 0.
REQ-027 The four control outputs are combinational from current inputs (zero latency); they do not depend on state.
REQ-028 FSM states, encoded on state_o: RUN=0, STALL=1, MEMWAIT=2.
REQ-029 Next state: wait_req -> MEMWAIT; else stall_req & !br_taken -> STALL; else RUN.
REQ-030 A branch held during a freeze flushes in the first unfrozen cycle.
REQ-031 8-bit wait counter: cleared on every cycle with !wait_req; increments each wait_req cycle; saturates at MEM_TIMEOUT.
REQ-032 mem_err sets in the cycle after the wait counter reaches MEM_TIMEOUT and stays set until reset; the freeze continues while wait_req holds.
REQ-033 No forwarding and a back-to-back dependency give a 2-cycle stall; forwarding with a load-use gives a 1-cycle stall.

Reset
REQ-034 While rst_n=0: state RUN (state_o=0), wait counter 0, mem_err 0, all stats counters 0.
REQ-035 Combinational outputs follow their inputs during reset; the pipeline registers themselves are reset by rst_n.
REQ-036 Reset during MEMWAIT returns to RUN on the first clock after deassertion without setting mem_err.

Configuration
REQ-037 Macro HAZARD_STATS_EN defined: add outputs stat_stall, stat_flush, stat_wait (32 bits each).
REQ-038 These counters count cycles with hz_stall & !pipe_freeze, hz_flush, and pipe_freeze respectively, and saturate at all-ones.
REQ-039 Macro HAZARD_STATS_EN undefined: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-040 Shared package holds the state enumeration (RUN/STALL/MEMWAIT), REG_W=4, and STAT_W=32.
REQ-041 Sub-module hazard_cmp: one source vs. one destination compare with valid/wb_en qualification, instantiated 4 times; everything else lives in hazard_ctrl.

Verification
REQ-042 fwd_en=0; src1=3 valid; ex_dest=3, ex_wb_en=1 -> hz_stall=hz_bubble=1, state_o=1 next cycle.
REQ-043 fwd_en=1, same as REQ-042 with ex_mem_rd=0 -> no stall; set ex_mem_rd=1 -> exactly one stall cycle.
REQ-044 stall_req and br_taken asserted together -> hz_flush=1, hz_stall=0, state_o=0.
REQ-045 mem_req=1, mem_ready=0 for 3 cycles with br_taken=1 -> pipe_freeze=1 for 3 cycles, then hz_flush=1 on cycle 4.
REQ-046 MEM_TIMEOUT=4, mem_ready held at 0 -> mem_err=1 after the 4th wait cycle; stays 1 after mem_ready=1 until rst_n=0.
REQ-047 HAZARD_STATS_EN defined: run 5 stalls and 2 flushes -> stat_stall=5, stat_flush=2; reset -> all counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the hazard control block.
package hazard_ctrl_pkg;

   localparam int REG_W  = 4;
   localparam int STAT_W = 32;

   // FSM encoding, also driven onto state_o for debug.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// One source register compared against one destination register.
// A match only counts when the source is really read and the
// destination is really written back.
module hazard_cmp
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             src_vld,
   input  logic [REG_W-1:0] dest,
   input  logic             wb_en,
   output logic             match
);

   // Qualified equality compare.
   always_comb begin
      match = src_vld & wb_en & (src == dest);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW / load-use stalls, branch flush,
// data-memory wait freeze with a sticky timeout flag.
// Optional build macro HAZARD_STATS_EN adds saturating event counters
// (stat_stall, stat_flush, stat_wait).
//
// Output priority: memory wait > taken branch > data-hazard stall.
// The four control outputs are purely combinational from the current
// inputs; the FSM only tracks what happened, for debug and stats.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fwd_en,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src1_vld,
   input  logic             id_src2_vld,
   input  logic [REG_W-1:0] ex_dest,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             ex_wb_en,
   input  logic             mem_wb_en,
   input  logic             ex_mem_rd,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             hz_stall,
   output logic             hz_bubble,
   output logic             hz_flush,
   output logic             pipe_freeze,
   output logic             mem_err,
`ifdef HAZARD_STATS_EN
   output logic [STAT_W-1:0] stat_stall,
   output logic [STAT_W-1:0] stat_flush,
   output logic [STAT_W-1:0] stat_wait,
`endif
   output logic [1:0]       state_o
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   logic   m1_ex, m2_ex, m1_mem, m2_mem;
   logic   raw, lu, stall_req, wait_req;
   state_t state;
   logic [7:0] wait_cnt;

   hazard_cmp u_cmp_s1_ex  (.src(id_src1), .src_vld(id_src1_vld), .dest(ex_dest),  .wb_en(ex_wb_en),  .match(m1_ex));
   hazard_cmp u_cmp_s2_ex  (.src(id_src2), .src_vld(id_src2_vld), .dest(ex_dest),  .wb_en(ex_wb_en),  .match(m2_ex));
   hazard_cmp u_cmp_s1_mem (.src(id_src1), .src_vld(id_src1_vld), .dest(mem_dest), .wb_en(mem_wb_en), .match(m1_mem));
   hazard_cmp u_cmp_s2_mem (.src(id_src2), .src_vld(id_src2_vld), .dest(mem_dest), .wb_en(mem_wb_en), .match(m2_mem));

   // Hazard detection and prioritised control outputs (zero latency).
   always_comb begin
      raw         = m1_ex | m2_ex | m1_mem | m2_mem;
      lu          = (m1_ex | m2_ex) & ex_mem_rd;
      stall_req   = fwd_en ? lu : raw;
      wait_req    = mem_req & ~mem_ready;
      hz_stall    = 1'b0;
      hz_bubble   = 1'b0;
      hz_flush    = 1'b0;
      pipe_freeze = 1'b0;
      if (wait_req) begin
         pipe_freeze = 1'b1;
         hz_stall    = 1'b1;
      end else if (br_taken) begin
         hz_flush    = 1'b1;
      end else if (stall_req) begin
         hz_stall    = 1'b1;
         hz_bubble   = 1'b1;
      end
   end

   // FSM, wait counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         mem_err  <= 1'b0;
      end else begin
         if (wait_req)
            state <= MEMWAIT;
         else if (stall_req && !br_taken)
            state <= STALL;
         else
            state <= RUN;

         if (!wait_req)
            wait_cnt <= 8'd0;
         else if (wait_cnt < TIMEOUT)
            wait_cnt <= wait_cnt + 8'd1;

         // The counter reaches TIMEOUT on this edge; flag it together.
         if (wait_req && (wait_cnt >= TIMEOUT - 8'd1))
            mem_err <= 1'b1;
      end
   end

   assign state_o = state;

`ifdef HAZARD_STATS_EN
   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_stall <= '0;
         stat_flush <= '0;
         stat_wait  <= '0;
      end else begin
         if (hz_stall && !pipe_freeze && (stat_stall != '1))
            stat_stall <= stat_stall + 1'b1;
         if (hz_flush && (stat_flush != '1))
            stat_flush <= stat_flush + 1'b1;
         if (pipe_freeze && (stat_wait != '1))
            stat_wait <= stat_wait + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fwd_en = 1'b0;
   logic [3:0] id_src1 = '0, id_src2 = '0, ex_dest = '0, mem_dest = '0;
   logic       id_src1_vld = 1'b0, id_src2_vld = 1'b0;
   logic       ex_wb_en = 1'b0, mem_wb_en = 1'b0, ex_mem_rd = 1'b0;
   logic       br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic       hz_stall, hz_bubble, hz_flush, pipe_freeze, mem_err;
   logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
   logic [31:0] stat_stall, stat_flush, stat_wait;
`endif

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
      .ex_dest(ex_dest), .mem_dest(mem_dest),
      .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_mem_rd(ex_mem_rd),
      .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .hz_stall(hz_stall), .hz_bubble(hz_bubble), .hz_flush(hz_flush),
      .pipe_freeze(pipe_freeze), .mem_err(mem_err),
`ifdef HAZARD_STATS_EN
      .stat_stall(stat_stall), .stat_flush(stat_flush), .stat_wait(stat_wait),
`endif
      .state_o(state_o)
   );

   // Clock.
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       fwd;
      logic [3:0] s1;  logic v1;
      logic [3:0] s2;  logic v2;
      logic [3:0] exd; logic exw; logic ld;
      logic [3:0] md;  logic mw;
      logic       br;  logic mreq; logic mrdy;
      logic [3:0] exp_ctl;   // {stall, bubble, flush, freeze}
      logic [1:0] exp_state; // state after the clock edge
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      fwd_en = v.fwd;
      id_src1 = v.s1; id_src1_vld = v.v1;
      id_src2 = v.s2; id_src2_vld = v.v2;
      ex_dest = v.exd; ex_wb_en = v.exw; ex_mem_rd = v.ld;
      mem_dest = v.md; mem_wb_en = v.mw;
      br_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
   endtask

   task automatic idle();
      vec_t v;
      v = '{"idle", 0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 4'b0000, 2'd0};
      drive(v);
   endtask

   function automatic logic [3:0] ctl();
      return {hz_stall, hz_bubble, hz_flush, pipe_freeze};
   endfunction

   // Advance one clock and return just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                 name        fwd s1 v1 s2 v2 exd exw ld md mw br mq mr  ctl      st
      vecs.push_back('{"idle",        0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"raw_ex",      0, 3,1, 0,0, 3,1,0, 0,0, 0,0,0, 4'b1100, 2'd1});
      vecs.push_back('{"raw_mem_s2",  0, 0,0, 5,1, 0,0,0, 5,1, 0,0,0, 4'b1100, 2'd1});
      vecs.push_back('{"raw_inval",   0, 3,0, 0,0, 3,1,0, 0,0, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"fwd_no_ld",   1, 3,1, 0,0, 3,1,0, 0,0, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"fwd_ld_use",  1, 3,1, 0,0, 3,1,1, 0,0, 0,0,0, 4'b1100, 2'd1});
      vecs.push_back('{"fwd_mem",     1, 0,0, 7,1, 0,0,0, 7,1, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"raw_no_wb",   0, 6,1, 0,0, 6,0,0, 0,0, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"raw_dest_ne", 0, 6,1, 6,1, 2,1,0, 9,1, 0,0,0, 4'b0000, 2'd0});
      vecs.push_back('{"stall_br",    0, 3,1, 0,0, 3,1,0, 0,0, 1,0,0, 4'b0010, 2'd0});
      vecs.push_back('{"br_only",     0, 0,0, 0,0, 0,0,0, 0,0, 1,0,0, 4'b0010, 2'd0});
      vecs.push_back('{"wait_all",    0, 3,1, 0,0, 3,1,0, 0,0, 1,1,0, 4'b1001, 2'd2});
      vecs.push_back('{"mem_done",    0, 3,1, 0,0, 3,1,0, 0,0, 0,1,1, 4'b1100, 2'd1});
      vecs.push_back('{"fwd_ld_s2",   1, 9,0, 9,1, 9,1,1, 0,0, 0,0,0, 4'b1100, 2'd1});
      vecs.push_back('{"fwd_ld_inv",  1, 9,0, 9,0, 9,1,1, 0,0, 0,0,0, 4'b0000, 2'd0});

      // Reset: state cleared, control outputs still follow inputs.
      drive(vecs[1]);
      #2;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_mem_err", 32'(mem_err), 32'd0);
      check("rst_comb_stall", 32'(ctl()), 32'b1100);
`ifdef HAZARD_STATS_EN
      check("rst_stat_stall", stat_stall, 32'd0);
`endif
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Table-driven single-cycle vectors.
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clk);
         check({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
         step();
         check({vecs[i].name, "_state"}, 32'(state_o), 32'(vecs[i].exp_state));
      end
      idle();
      step();

      // Branch held across a 3-cycle freeze flushes once memory completes.
      mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("frz_ctl", 32'(ctl()), 32'b1001);
         step();
         check("frz_state", 32'(state_o), 32'd2);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      check("frz_then_flush", 32'(ctl()), 32'b0010);
      step();
      check("frz_after_state", 32'(state_o), 32'd0);
      check("frz_no_err", 32'(mem_err), 32'd0);
      idle();
      step();

      // Timeout: mem_err after the 4th wait cycle, sticky until reset.
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         step();
         check($sformatf("to_err_c%0d", i), 32'(mem_err), (i == TO) ? 32'd1 : 32'd0);
      end
      step();
      check("to_err_hold", 32'(mem_err), 32'd1);
      @(negedge clk);
      check("to_freeze_hold", 32'(pipe_freeze), 32'd1);
      mem_ready = 1'b1;
      step();
      step();
      check("to_err_sticky", 32'(mem_err), 32'd1);
      idle();
      rst_n = 1'b0;
      #1;
      check("to_err_reset", 32'(mem_err), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Reset in MEMWAIT returns to RUN without raising mem_err.
      mem_req = 1'b1; mem_ready = 1'b0;
      step();
      step();
      check("mw_state", 32'(state_o), 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      #1;
      check("mw_rst_state", 32'(state_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("mw_run", 32'(state_o), 32'd0);
      check("mw_no_err", 32'(mem_err), 32'd0);

`ifdef HAZARD_STATS_EN
      // 5 stall cycles, 2 flush cycles.
      drive(vecs[1]);
      repeat (5) step();
      idle();
      br_taken = 1'b1;
      repeat (2) step();
      idle();
      step();
      check("stat_stall", stat_stall, 32'd5);
      check("stat_flush", stat_flush, 32'd2);
      check("stat_wait", stat_wait, 32'd0);
      rst_n = 1'b0;
      #1;
      check("stat_rst", stat_stall | stat_flush | stat_wait, 32'd0);
      rst_n = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
